// File: rtl/dram_rd_req_issuer_if.sv
// dram_rd_req_issuer_if: descriptor, DRAM request/response and head-metadata signals of the row-load issuer.
interface dram_rd_req_issuer_if #(
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 8,
    parameter int XBAR_W  = 16,
    parameter int SPAD_AW = 10
);
    logic               desc_valid;
    logic               desc_ready;
    logic [ADDR_W-1:0]  desc_dram_addr;
    logic [SPAD_AW-1:0] desc_spad_addr;
    logic [XBAR_W-1:0]  desc_xbar;
    logic [2:0]         desc_num_request;
    logic               dram_req_valid;
    logic               dram_req_ready;
    logic [ADDR_W-1:0]  dram_req_addr;
    logic [ID_W-1:0]    dram_req_id;
    logic               dram_res_valid;
    logic [2:0]         num_request;
    logic [SPAD_AW-1:0] spad_addr;
    logic [XBAR_W-1:0]  xbar;
    logic               meta_valid;
    logic               rsp_err;

    modport master (
        input  desc_valid, desc_dram_addr, desc_spad_addr, desc_xbar, desc_num_request,
               dram_req_ready, dram_res_valid,
        output desc_ready, dram_req_valid, dram_req_addr, dram_req_id,
               num_request, spad_addr, xbar, meta_valid, rsp_err
    );

    modport slave (
        output desc_valid, desc_dram_addr, desc_spad_addr, desc_xbar, desc_num_request,
               dram_req_ready, dram_res_valid,
        input  desc_ready, dram_req_valid, dram_req_addr, dram_req_id,
               num_request, spad_addr, xbar, meta_valid, rsp_err
    );
endinterface

// File: rtl/dram_rd_req_issuer.sv
// dram_rd_req_issuer: splits row descriptors into 64-bit DRAM read beats and
// keeps per-row metadata in an in-order queue whose head feeds the write latch.
module dram_rd_req_issuer #(
    parameter int ADDR_W      = 32,
    parameter int ID_W        = 8,
    parameter int XBAR_W      = 16,
    parameter int SPAD_AW     = 10,
    parameter int ROW_Q_DEPTH = 4
) (
    input logic clk,
    input logic n_rst,
    dram_rd_req_issuer_if.master bus
);
    localparam int PW = $clog2(ROW_Q_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = ID_W - 3;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t             state_q;
    logic [ADDR_W-1:0]  base_q;
    logic [2:0]         nreq_q;
    logic [2:0]         beat_q;
    logic [TW-1:0]      tag_q;
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic [2:0]         rsp_cnt_q;
    logic               rsp_err_q;
    logic [2:0]         q_num  [ROW_Q_DEPTH];
    logic [SPAD_AW-1:0] q_spad [ROW_Q_DEPTH];
    logic [XBAR_W-1:0]  q_xbar [ROW_Q_DEPTH];
    logic               nonempty;
    logic               push;
    logic               pop;

    always_comb begin
        nonempty = count_q != '0;
        push     = bus.desc_valid && bus.desc_ready;
        pop      = bus.dram_res_valid && nonempty && rsp_cnt_q == q_num[rd_ptr_q];
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    assign bus.desc_ready     = state_q == IDLE && count_q < CW'(ROW_Q_DEPTH);
    assign bus.dram_req_valid = state_q == ISSUE;
    assign bus.dram_req_addr  = base_q + ADDR_W'({beat_q, 3'b000});
    assign bus.dram_req_id    = {tag_q, beat_q};
    assign bus.meta_valid     = nonempty;
    assign bus.num_request    = nonempty ? q_num[rd_ptr_q]  : '0;
    assign bus.spad_addr      = nonempty ? q_spad[rd_ptr_q] : '0;
    assign bus.xbar           = nonempty ? q_xbar[rd_ptr_q] : '0;
    assign bus.rsp_err        = rsp_err_q;

    // Queue storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            q_num[wr_ptr_q]  <= bus.desc_num_request;
            q_spad[wr_ptr_q] <= bus.desc_spad_addr;
            q_xbar[wr_ptr_q] <= bus.desc_xbar;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            nreq_q    <= '0;
            beat_q    <= '0;
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rsp_cnt_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (push) begin
                    base_q  <= bus.desc_dram_addr;
                    nreq_q  <= bus.desc_num_request;
                    beat_q  <= '0;
                    state_q <= ISSUE;
                end
                ISSUE: if (bus.dram_req_ready) begin
                    if (beat_q == nreq_q) begin
                        tag_q   <= tag_q + TW'(1);
                        state_q <= IDLE;
                    end else begin
                        beat_q <= beat_q + 3'd1;
                    end
                end
            endcase
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            // The latch samples the head this cycle; the pop shows up next cycle.
            if (bus.dram_res_valid && nonempty) rsp_cnt_q <= pop ? 3'd0 : rsp_cnt_q + 3'd1;
            if (bus.dram_res_valid && !nonempty) rsp_err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dram_rd_req_issuer.sv
// tb_dram_rd_req_issuer: randomized scoreboard bench; a row/beat queue model predicts
// requests, head metadata, desc_ready and rsp_err, and a negedge monitor compares.
module tb_dram_rd_req_issuer;
    localparam int ADDR_W = 32, ID_W = 8, XBAR_W = 16, SPAD_AW = 10, DEPTH = 4;
    localparam int TAGS = 1 << (ID_W - 3);

    typedef struct {
        logic [2:0]         num;
        logic [SPAD_AW-1:0] spad;
        logic [XBAR_W-1:0]  xbar;
        int                 got;
    } row_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
    } beat_t;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    int   checks = 0, failures = 0;
    int   pend_rsp = 0, rows_acc = 0;
    int   rsp_pct = 0, rdy_pct = 100;
    bit   rsp_any = 1'b0, err_m = 1'b0;
    row_t  rows[$];
    beat_t beats[$];

    dram_rd_req_issuer_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .XBAR_W(XBAR_W), .SPAD_AW(SPAD_AW)) bus ();

    dram_rd_req_issuer #(.ADDR_W(ADDR_W), .ID_W(ID_W), .XBAR_W(XBAR_W), .SPAD_AW(SPAD_AW),
                         .ROW_Q_DEPTH(DEPTH)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare against the model, then apply this cycle's handshakes to it.
    initial forever begin
        bit    exp_rdy;
        row_t  h;
        beat_t b;
        @(negedge clk);
        if (!n_rst) begin
            rows.delete();
            beats.delete();
            pend_rsp = 0;
            rows_acc = 0;
            err_m    = 1'b0;
            continue;
        end
        exp_rdy = beats.size() == 0 && rows.size() < DEPTH;
        chk("desc_ready", bus.desc_ready, exp_rdy);
        chk("req_valid", bus.dram_req_valid, beats.size() != 0);
        chk("meta_valid", bus.meta_valid, rows.size() != 0);
        chk("num_request", bus.num_request, rows.size() != 0 ? rows[0].num : 3'd0);
        chk("spad_addr", bus.spad_addr, rows.size() != 0 ? rows[0].spad : '0);
        chk("xbar", bus.xbar, rows.size() != 0 ? rows[0].xbar : '0);
        chk("rsp_err", bus.rsp_err, err_m);
        if (bus.dram_req_valid && beats.size() != 0) begin
            chk("req_addr", bus.dram_req_addr, beats[0].addr);
            chk("req_id", bus.dram_req_id, beats[0].id);
            if (bus.dram_req_ready) begin
                beats.pop_front();
                pend_rsp++;
            end
        end
        if (bus.dram_res_valid) begin
            if (rows.size() == 0) err_m = 1'b1;
            else begin
                h = rows[0];
                h.got++;
                rows[0] = h;
                if (h.got == int'(h.num) + 1) rows.pop_front();
                if (pend_rsp > 0) pend_rsp--;
            end
        end
        if (bus.desc_valid && exp_rdy) begin
            h.num  = bus.desc_num_request;
            h.spad = bus.desc_spad_addr;
            h.xbar = bus.desc_xbar;
            h.got  = 0;
            rows.push_back(h);
            for (int i = 0; i <= int'(bus.desc_num_request); i++) begin
                b.addr = bus.desc_dram_addr + ADDR_W'(8 * i);
                b.id   = ID_W'((rows_acc % TAGS) * 8 + i);
                beats.push_back(b);
            end
            rows_acc++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        bus.dram_res_valid = (pend_rsp > 0 || rsp_any) && ($urandom_range(99) < rsp_pct);
        bus.dram_req_ready = $urandom_range(99) < rdy_pct;
    end

    task automatic send(input logic [ADDR_W-1:0] a, input logic [SPAD_AW-1:0] s,
                        input logic [XBAR_W-1:0] x, input logic [2:0] n);
        bit ok = 1'b0;
        bus.desc_valid       = 1'b1;
        bus.desc_dram_addr   = a;
        bus.desc_spad_addr   = s;
        bus.desc_xbar        = x;
        bus.desc_num_request = n;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            ok = bus.desc_ready;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.desc_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk);
            ok = rows.size() == 0 && beats.size() == 0;
        end
        if (!ok) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        bus.desc_valid       = 1'b0;
        bus.desc_dram_addr   = '0;
        bus.desc_spad_addr   = '0;
        bus.desc_xbar        = '0;
        bus.desc_num_request = '0;
        bus.dram_req_ready   = 1'b1;
        bus.dram_res_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", bus.dram_req_valid, 0);
        chk("rst_meta_valid", bus.meta_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_num_request", bus.num_request, 0);
        chk("rst_spad_addr", bus.spad_addr, 0);
        chk("rst_xbar", bus.xbar, 0);
        chk("rst_req_id", bus.dram_req_id, 0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("rst_desc_ready", bus.desc_ready, 1);
        @(posedge clk);
        #1;
        // Single 8-beat row at 0x1000, ready held high, responses afterwards.
        send(32'h1000, 10'h05, 16'hABCD, 3'd7);
        rsp_pct = 100;
        wait_idle();
        // Fill the queue with one-beat rows, then free one slot while a fifth row waits.
        rsp_pct = 0;
        for (int i = 0; i < DEPTH; i++) send(ADDR_W'(32'h2000 + 256 * i), SPAD_AW'(i + 1), XBAR_W'(i), 3'd0);
        fork
            send(32'h3000, 10'h3F, 16'h1234, 3'd2);
            begin
                repeat (4) @(posedge clk);
                rsp_pct = 100;
            end
        join
        wait_idle();
        // Randomized traffic, long enough to wrap the row tag several times.
        for (int r = 0; r < 300; r++) begin
            if (r % 40 == 0) begin
                rsp_pct = $urandom_range(5, 100);
                rdy_pct = $urandom_range(30, 100);
            end
            send({$urandom, 3'b000} & {ADDR_W{1'b1}}, SPAD_AW'($urandom), XBAR_W'($urandom), 3'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rsp_pct = 100;
        rdy_pct = 100;
        wait_idle();
        // Response with an empty queue sets the sticky error.
        rsp_any = 1'b1;
        repeat (2) @(posedge clk);
        rsp_any = 1'b0;
        rsp_pct = 0;
        repeat (3) @(negedge clk);
        chk("rsp_err_sticky", bus.rsp_err, 1);
        // Reset in the middle of a row abandons everything immediately.
        @(posedge clk);
        #1;
        rdy_pct = 40;
        bus.desc_valid       = 1'b1;
        bus.desc_dram_addr   = 32'h4000;
        bus.desc_spad_addr   = 10'h2A;
        bus.desc_xbar        = 16'h00FF;
        bus.desc_num_request = 3'd7;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.dram_req_valid;
        end
        if (!ok) chk("issue_timeout", 0, 1);
        #2;
        bus.desc_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("mid_rst_req_valid", bus.dram_req_valid, 0);
        chk("mid_rst_meta_valid", bus.meta_valid, 0);
        chk("mid_rst_rsp_err", bus.rsp_err, 0);
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
